// File: rtl/trig_table_arbiter.sv
// Arbiter and 3-stage lookup pipeline for the shared quarter-wave trig table.
// Host loads win outright; CTR and RAY lookups share the read port round-robin.
module trig_table_arbiter #(
    parameter int FULL_TURN = 2400,
    parameter int QUARTER   = 600
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load_req,
    input  logic [9:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        load_ack,
    input  logic        ctr_req,
    input  logic [15:0] ctr_angle,
    output logic        ctr_ack,
    output logic        ctr_valid,
    output logic [31:0] ctr_data,
    input  logic        ray_req,
    input  logic [15:0] ray_angle,
    output logic        ray_ack,
    output logic        ray_valid,
    output logic [31:0] ray_data,
    output logic [9:0]  tbl_addr,
    output logic        tbl_wren,
    output logic [31:0] tbl_wdata,
    input  logic [31:0] tbl_q,
    output logic        busy,
    output logic        err_range
);

    localparam logic signed [17:0] FT_S  = 18'(FULL_TURN);
    localparam logic signed [17:0] FT2_S = 18'(2 * FULL_TURN);
    localparam logic signed [17:0] NFT_S = 18'(-FULL_TURN);
    localparam logic [11:0] FT_N = 12'(FULL_TURN);
    localparam logic [11:0] Q1   = 12'(QUARTER);
    localparam logic [11:0] Q2   = 12'(2 * QUARTER);
    localparam logic [11:0] Q3   = 12'(3 * QUARTER);
    localparam logic [9:0]  A_Q2 = 10'(2 * QUARTER);
    localparam logic [9:0]  A_Q4 = 10'(4 * QUARTER);
    localparam logic [9:0]  LAST = 10'(QUARTER);

    logic               last_ray;
    logic               lk_go;
    logic signed [15:0] a;
    logic signed [17:0] a_x;
    logic               a_hi;
    logic               a_bad;
    logic [11:0]        n;
    logic               q0, q1, q2, q3;
    logic [9:0]         f_addr;
    logic               f_ns, f_nc;
    logic               s1_v, s1_tag, s1_ns, s1_nc;
    logic               s2_v, s2_tag, s2_ns, s2_nc;
    logic [15:0]        sin_r, cos_r;

    assign load_ack = load_req;
    assign ctr_ack  = !load_req && ctr_req && (!ray_req || last_ray);
    assign ray_ack  = !load_req && ray_req && (!ctr_req || !last_ray);
    assign lk_go    = ctr_ack | ray_ack;

    assign a     = ctr_ack ? ctr_angle : ray_angle;
    assign a_x   = {{2{a[15]}}, a};
    assign a_hi  = a_x >= FT_S;
    assign a_bad = (a_x < NFT_S) || (a_x >= FT2_S);

    // Legal results lie in 0..FULL_TURN-1, so 12-bit modular math suffices
    always_comb begin
        n = a[11:0];
        if (a[15])
            n = a[11:0] + FT_N;
        else if (a_hi)
            n = a[11:0] - FT_N;
    end

    assign q0 = n <= Q1;
    assign q1 = (n > Q1) && (n <= Q2);
    assign q2 = (n > Q2) && (n <= Q3);
    assign q3 = n > Q3;

    always_comb begin
        f_addr = '0;
        f_ns   = 1'b0;
        f_nc   = 1'b0;
        unique case (1'b1)
            q0: f_addr = n[9:0];
            q1: begin
                f_addr = A_Q2 - n[9:0];
                f_nc   = 1'b1;
            end
            q2: begin
                f_addr = n[9:0] - A_Q2;
                f_ns   = 1'b1;
                f_nc   = 1'b1;
            end
            q3: begin
                f_addr = A_Q4 - n[9:0];
                f_ns   = 1'b1;
            end
        endcase
        if (a_bad) begin
            f_addr = '0;
            f_ns   = 1'b0;
            f_nc   = 1'b0;
        end
    end

    assign sin_r = s2_ns ? ~tbl_q[31:16] + 16'd1 : tbl_q[31:16];
    assign cos_r = s2_nc ? ~tbl_q[15:0] + 16'd1 : tbl_q[15:0];
    assign busy  = s1_v | s2_v;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_ray  <= 1'b1;
            tbl_addr  <= '0;
            tbl_wren  <= 1'b0;
            tbl_wdata <= '0;
            err_range <= 1'b0;
            s1_v      <= 1'b0;
            s1_tag    <= 1'b0;
            s1_ns     <= 1'b0;
            s1_nc     <= 1'b0;
            s2_v      <= 1'b0;
            s2_tag    <= 1'b0;
            s2_ns     <= 1'b0;
            s2_nc     <= 1'b0;
            ctr_valid <= 1'b0;
            ray_valid <= 1'b0;
            ctr_data  <= '0;
            ray_data  <= '0;
        end else begin
            tbl_wren <= 1'b0;
            if (load_ack) begin
                tbl_addr  <= load_addr;
                tbl_wdata <= load_data;
                tbl_wren  <= load_addr <= LAST;
                if (load_addr > LAST)
                    err_range <= 1'b1;
            end else if (lk_go) begin
                tbl_addr <= f_addr;
                if (a_bad)
                    err_range <= 1'b1;
            end
            if (ctr_ack)
                last_ray <= 1'b0;
            else if (ray_ack)
                last_ray <= 1'b1;
            s1_v      <= lk_go;
            s1_tag    <= ray_ack;
            s1_ns     <= f_ns;
            s1_nc     <= f_nc;
            s2_v      <= s1_v;
            s2_tag    <= s1_tag;
            s2_ns     <= s1_ns;
            s2_nc     <= s1_nc;
            ctr_valid <= s2_v && !s2_tag;
            ray_valid <= s2_v && s2_tag;
            if (s2_v && !s2_tag)
                ctr_data <= {sin_r, cos_r};
            if (s2_v && s2_tag)
                ray_data <= {sin_r, cos_r};
        end
    end

endmodule
